gp_rx_depacketizer: RTL

GP_RX_DEPACKETIZER -- requirements
Module: gp_rx_depacketizer

---
 rtl/gp_rx_pkg.sv | 24 ++
 rtl/gp_axis_skid.sv | 84 ++++++++
 rtl/gp_rx_depacketizer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/gp_rx_pkg.sv
// gp_rx_pkg: shared definitions for the receive depacketizer.
//   state_e    : depacketizer FSM states (HDR, PAY, DROP)
//   HDR_*_LSB  : bit offsets of the header fields inside the header beat
//   hdr_t      : decoded header; fields are 32 bits wide and are narrowed
//                to the instance parameter widths by the user
package gp_rx_pkg;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PAY  = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_SRC_LSB  = 8;
  localparam int HDR_LEN_LSB  = 16;

  typedef struct packed {
    logic [31:0] len;
    logic [31:0] src;
    logic [31:0] dest;
  } hdr_t;

endpackage

// File: rtl/gp_axis_skid.sv
// gp_axis_skid: two-entry AXI-Stream skid buffer carrying tdata/tkeep/
// tlast/tdest/tid per entry.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   s_valid_i/s_*_i        : upstream beat, s_ready_o = buffer not full
//   m_valid_o/m_*_o        : downstream beat, held stable until m_ready_i
// A beat written on one edge is visible on m_* after that edge, giving
// exactly one cycle of latency. Entries are cleared on reset so the
// outputs read zero while reset is asserted.
module gp_axis_skid
  import gp_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    s_valid_i,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic [DATA_WIDTH/8-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic [DEST_WIDTH-1:0]   s_dest_i,
  input  logic [ID_WIDTH-1:0]     s_id_i,
  output logic                    s_ready_o,
  output logic                    m_valid_o,
  output logic [DATA_WIDTH-1:0]   m_data_o,
  output logic [DATA_WIDTH/8-1:0] m_keep_o,
  output logic                    m_last_o,
  output logic [DEST_WIDTH-1:0]   m_dest_o,
  output logic [ID_WIDTH-1:0]     m_id_o,
  input  logic                    m_ready_i
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] keep;
    logic                    last;
    logic [DEST_WIDTH-1:0]   dest;
    logic [ID_WIDTH-1:0]     id;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     head;
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] cnt_q, cnt_d;
  logic       push, pop;

  assign s_ready_o = (cnt_q != 2'd2);
  assign m_valid_o = (cnt_q != 2'd0);
  assign push      = s_valid_i && s_ready_o;
  assign pop       = m_valid_o && m_ready_i;

  assign head     = mem_q[rd_ptr_q];
  assign m_data_o = head.data;
  assign m_keep_o = head.keep;
  assign m_last_o = head.last;
  assign m_dest_o = head.dest;
  assign m_id_o   = head.id;

  always_comb begin
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{data: s_data_i, keep: s_keep_i, last: s_last_i,
                             dest: s_dest_i, id: s_id_i};
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gp_rx_depacketizer.sv
// gp_rx_depacketizer: strips a one-beat header from each incoming packet
// and forwards the payload toward the kernel router with tdest/tid.
//   CLK, rstn          : clock, asynchronous active-low reset
//   s_axis_*           : framed network stream (header beat + payload)
//   m_axis_*           : payload stream, tdest/tid from the header
//   drop_pulse         : one-cycle strobe per discarded/truncated packet
//   err_count          : 32-bit saturating drop counter, present only when
//                        GP_RX_ERR_CNT_EN is defined
// Header beat: [DEST_WIDTH-1:0] dest, [15:8] src id, [16+LEN_WIDTH-1:16]
// payload length in beats. Packets with L=0 or dest>MAX_DEST are dropped.
module gp_rx_depacketizer
  import gp_rx_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          DEST_WIDTH = 8,
  parameter int          ID_WIDTH   = 8,
  parameter int          LEN_WIDTH  = 16,
  parameter int unsigned MAX_DEST   = 255
) (
  input  logic                    CLK,
  input  logic                    rstn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  input  logic                    m_axis_tready,
`ifdef GP_RX_ERR_CNT_EN
  output logic [31:0]             err_count,
`endif
  output logic                    drop_pulse
);

  state_e                state_q, state_d;
  logic                  rdy_q;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  drop_q, drop_d;
  hdr_t                  hdr;
  logic                  hdr_ok;
  logic                  beat_acc;
  logic                  push, push_last;
  logic                  skid_ready;

  always_comb begin
    hdr.dest = 32'(s_axis_tdata[HDR_DEST_LSB +: DEST_WIDTH]);
    hdr.src  = 32'(s_axis_tdata[HDR_SRC_LSB +: ID_WIDTH]);
    hdr.len  = 32'(s_axis_tdata[HDR_LEN_LSB +: LEN_WIDTH]);
  end

  assign hdr_ok = (hdr.len != 32'd0) && (hdr.dest <= MAX_DEST);

  // rdy_q keeps tready low while in reset and for no longer than the first
  // edge after release. Only the payload state is gated by skid space, so
  // headers and dropped beats are never held off by a stalled kernel side.
  assign s_axis_tready = rdy_q && ((state_q != PAY) || skid_ready);
  assign beat_acc      = s_axis_tvalid && s_axis_tready;
  assign cnt_inc       = cnt_q + LEN_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    dest_d    = dest_q;
    id_d      = id_q;
    drop_d    = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    unique case (state_q)
      HDR: begin
        if (beat_acc) begin
          if (s_axis_tlast) begin
            drop_d = 1'b1;
          end else if (hdr_ok) begin
            state_d = PAY;
            cnt_d   = '0;
            len_d   = LEN_WIDTH'(hdr.len);
            dest_d  = DEST_WIDTH'(hdr.dest);
            id_d    = ID_WIDTH'(hdr.src);
          end else begin
            state_d = DROP;
          end
        end
      end
      PAY: begin
        if (beat_acc) begin
          push  = 1'b1;
          cnt_d = cnt_inc;
          if (s_axis_tlast) begin
            // Short packet: forwarded as-is but still flagged.
            push_last = 1'b1;
            state_d   = HDR;
            cnt_d     = '0;
            drop_d    = (cnt_inc != len_q);
          end else if (cnt_inc == len_q) begin
            // Length satisfied before input tlast: close the output packet
            // now and swallow the remainder; the strobe fires at its tlast.
            push_last = 1'b1;
            state_d   = DROP;
            cnt_d     = '0;
          end
        end
      end
      DROP: begin
        if (beat_acc && s_axis_tlast) begin
          state_d = HDR;
          drop_d  = 1'b1;
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      state_q <= HDR;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      dest_q  <= '0;
      id_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dest_q  <= dest_d;
      id_q    <= id_d;
      drop_q  <= drop_d;
    end
  end

  assign drop_pulse = drop_q;

  gp_axis_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEST_WIDTH (DEST_WIDTH),
    .ID_WIDTH   (ID_WIDTH)
  ) u_skid (
    .clk_i     (CLK),
    .rst_ni    (rstn),
    .s_valid_i (push),
    .s_data_i  (s_axis_tdata),
    .s_keep_i  (s_axis_tkeep),
    .s_last_i  (push_last),
    .s_dest_i  (dest_q),
    .s_id_i    (id_q),
    .s_ready_o (skid_ready),
    .m_valid_o (m_axis_tvalid),
    .m_data_o  (m_axis_tdata),
    .m_keep_o  (m_axis_tkeep),
    .m_last_o  (m_axis_tlast),
    .m_dest_o  (m_axis_tdest),
    .m_id_o    (m_axis_tid),
    .m_ready_i (m_axis_tready)
  );

`ifdef GP_RX_ERR_CNT_EN
  logic [31:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (drop_q && (err_q != 32'hFFFF_FFFF)) begin
      err_d = err_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`endif

endmodule
